// File: rtl/conv_layer_seq.sv
// conv_layer_seq: sequences conv-engine jobs channel-major over layers, with watchdog and abort.
module conv_layer_seq #(
  parameter int MAX_LAYERS = 4,
  parameter int MAX_CH     = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(MAX_LAYERS+1)-1:0] cfg_layers,
  input  logic [$clog2(MAX_CH+1)-1:0]     cfg_channels,
  input  logic                            abort,
  input  logic                            eng_done,
  output logic                            busy,
  output logic                            done,
  output logic                            error,
  output logic                            eng_start,
  output logic [$clog2(MAX_LAYERS)-1:0]   eng_layer,
  output logic [$clog2(MAX_CH)-1:0]       eng_ch,
  output logic                            eng_src_buf,
  output logic                            eng_abort
);
  localparam int LW = $clog2(MAX_LAYERS+1);
  localparam int CW = $clog2(MAX_CH+1);
  localparam int LB = $clog2(MAX_LAYERS);
  localparam int CB = $clog2(MAX_CH);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic [LW-1:0] r_nl;
  logic [CW-1:0] r_nc;
  logic [LB-1:0] r_layer;
  logic [CB-1:0] r_ch;
  logic [WW-1:0] r_wd;
  logic r_err, r_abt;
  logic w_cfg_ok, w_accept, w_last_ch, w_last_l, w_expire, w_abort;
  assign w_cfg_ok  = cfg_layers != '0 && cfg_layers <= LW'(MAX_LAYERS) &&
                     cfg_channels != '0 && cfg_channels <= CW'(MAX_CH);
  assign w_accept  = r_state == IDLE && start && w_cfg_ok;
  assign w_last_ch = CW'(r_ch) == r_nc - CW'(1);
  assign w_last_l  = LW'(r_layer) == r_nl - LW'(1);
  assign w_expire  = r_wd == WW'(TIMEOUT-1);
  assign w_abort   = abort && r_state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // abort outranks eng_done, which outranks watchdog expiry
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = w_accept ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = eng_done ? NEXT : w_expire ? ERR : WAIT;
      NEXT:    w_next = (w_last_ch && w_last_l) ? DONE : ISSUE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_nl    <= '0;
      r_nc    <= '0;
      r_layer <= '0;
      r_ch    <= '0;
      r_wd    <= '0;
      r_err   <= 1'b0;
      r_abt   <= 1'b0;
    end else begin
      r_abt <= w_abort && r_state != ERR;
      if (w_accept) begin
        r_nl    <= cfg_layers;
        r_nc    <= cfg_channels;
        r_layer <= '0;
        r_ch    <= '0;
        r_err   <= 1'b0;
      end else if (r_state == IDLE && start) r_err <= 1'b1;
      if (w_next == ERR) r_err <= 1'b1;
      if (r_state == ISSUE) r_wd <= '0;
      else if (r_state == WAIT && !eng_done && !w_expire) r_wd <= r_wd + WW'(1);
      // the final job's coordinates are held rather than advanced past the end
      if (r_state == NEXT && !abort && !(w_last_ch && w_last_l)) begin
        r_ch <= w_last_ch ? '0 : r_ch + CB'(1);
        if (w_last_ch) r_layer <= r_layer + LB'(1);
      end
    end
  always_comb begin
    busy        = r_state != IDLE;
    done        = r_state == DONE;
    eng_start   = r_state == ISSUE;
    eng_abort   = r_state == ERR || r_abt;
    error       = r_err;
    eng_layer   = r_layer;
    eng_ch      = r_ch;
    eng_src_buf = r_layer[0];
  end
endmodule

// File: tb/tb_conv_layer_seq.sv
// tb_conv_layer_seq: random and directed runs against a job-list model with a scoreboard monitor.
module tb_conv_layer_seq;
  logic clk = 0, rst = 1, start = 0, abort = 0, eng_done_auto = 0, eng_done_man = 0;
  logic [2:0] cfg_layers = 0;
  logic [4:0] cfg_channels = 0;
  logic eng_done, busy, done, error, eng_start, eng_src_buf, eng_abort;
  logic [1:0] eng_layer;
  logic [3:0] eng_ch;
  assign eng_done = eng_done_auto | eng_done_man;
  conv_layer_seq #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_layers(cfg_layers), .cfg_channels(cfg_channels),
    .abort(abort), .eng_done(eng_done), .busy(busy), .done(done), .error(error),
    .eng_start(eng_start), .eng_layer(eng_layer), .eng_ch(eng_ch),
    .eng_src_buf(eng_src_buf), .eng_abort(eng_abort));
  typedef struct {int l; int c;} job_t;
  job_t q[$];
  int total = 0, bad = 0, cyc = 0, n_start = 0, n_done = 0, n_abort = 0;
  int run_id = 0, prev_run = -1, last_start = 0, exp_gap = 0, dly = 1, eng_cnt = 0;
  bit resp = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // engine stand-in: answers eng_done dly cycles after each eng_start when resp is set
  always @(negedge clk) begin
    eng_done_auto = 0;
    if (rst) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done_auto = 1;
      end
      if (eng_start && resp) eng_cnt = dly;
    end
  end
  always @(negedge clk) begin
    job_t j;
    if (eng_start) begin
      n_start++;
      if (q.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        j = q.pop_front();
        chk("job_layer", int'(eng_layer), j.l);
        chk("job_ch", int'(eng_ch), j.c);
        chk("job_src_buf", int'(eng_src_buf), j.l % 2);
      end
      if (exp_gap != 0 && prev_run == run_id) chk("job_gap", cyc - last_start, exp_gap);
      prev_run = run_id;
      last_start = cyc;
    end
    if (done) begin
      n_done++;
      if (exp_gap != 0) chk("done_latency", cyc - last_start, exp_gap);
    end
    if (eng_abort) n_abort++;
  end
  task automatic go(int l, int c);
    run_id++;
    if (l >= 1 && l <= 4 && c >= 1 && c <= 16)
      for (int li = 0; li < l; li++)
        for (int ci = 0; ci < c; ci++) q.push_back('{li, ci});
    cfg_layers = 3'(l);
    cfg_channels = 5'(c);
    start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  function automatic logic sig(int which);
    return which == 0 ? done : which == 1 ? eng_abort : eng_start;
  endfunction
  task automatic wait_for(string name, int budget, int which);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sig(which)) break;
    end
    chk(name, int'(k < budget), 1);
  endtask
  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_eng_done();
    @(posedge clk); #1 eng_done_man = 1;
    @(posedge clk); #1 eng_done_man = 0;
  endtask
  task automatic full_run(string name, int l, int c, int d);
    int d0;
    d0 = n_done;
    resp = 1; dly = d; exp_gap = d + 2;
    go(l, c);
    wait_for(name, 2000, 0);
    chk("final_layer", int'(eng_layer), l - 1);
    chk("final_ch", int'(eng_ch), c - 1);
    chk("run_error", int'(error), 0);
    @(negedge clk);
    chk("idle_after_done", int'(busy), 0);
    chk("done_count", n_done - d0, 1);
    chk("jobs_left", q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    int s0, d0, a0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({busy, done, error, eng_start, eng_abort, eng_layer, eng_ch, eng_src_buf}), 0);
    @(posedge clk); #1 rst = 0;
    cycles(1);
    s0 = n_start;
    full_run("done_2x3", 2, 3, 5);
    chk("starts_2x3", n_start - s0, 6);
    for (int i = 0; i < 6; i++)
      full_run("done_rand", $urandom_range(1, 4), $urandom_range(1, 16), $urandom_range(1, 8));
    s0 = n_start;
    go(2, 0);
    @(negedge clk);
    chk("bad_ch_error", int'(error), 1);
    chk("bad_ch_busy", int'(busy), 0);
    @(posedge clk); #1;
    go(5, 2);
    @(negedge clk);
    chk("bad_layers_error", int'(error), 1);
    cycles(3);
    @(negedge clk);
    chk("bad_cfg_busy", int'(busy), 0);
    chk("bad_cfg_starts", n_start - s0, 0);
    @(posedge clk); #1;
    resp = 1; dly = 1; exp_gap = 3;
    go(1, 1);
    @(negedge clk);
    chk("error_cleared", int'(error), 0);
    chk("valid_busy", int'(busy), 1);
    wait_for("done_after_bad", 100, 0);
    @(posedge clk); #1;
    resp = 0; exp_gap = 0; a0 = n_abort; d0 = n_done;
    go(1, 1);
    wait_for("timeout_abort", 100, 1);
    chk("timeout_latency", cyc - last_start, 17);
    chk("timeout_error", int'(error), 1);
    @(negedge clk);
    chk("timeout_idle", int'(busy), 0);
    chk("timeout_abort_once", int'(eng_abort), 0);
    chk("timeout_error_held", int'(error), 1);
    chk("timeout_aborts", n_abort - a0, 1);
    chk("timeout_no_done", n_done - d0, 0);
    @(posedge clk); #1;
    a0 = n_abort; d0 = n_done;
    go(1, 3);
    wait_for("l0c0_start", 50, 2);
    pulse_eng_done();
    wait_for("l0c1_start", 50, 2);
    cycles(2);
    abort = 1; eng_done_man = 1;
    @(posedge clk); #1 abort = 0; eng_done_man = 0;
    @(negedge clk);
    chk("abort_pulse", int'(eng_abort), 1);
    chk("abort_idle", int'(busy), 0);
    chk("abort_error", int'(error), 0);
    cycles(4);
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_aborts", n_abort - a0, 1);
    chk("abort_jobs_left", q.size(), 1);
    q.delete();
    go(2, 2);
    wait_for("rst_l0c0", 50, 2);
    pulse_eng_done();
    wait_for("rst_l0c1", 50, 2);
    cycles(2);
    a0 = n_abort; d0 = n_done;
    rst = 1;
    @(negedge clk);
    chk("midrun_reset_outputs", int'({busy, done, error, eng_start, eng_abort, eng_layer, eng_ch, eng_src_buf}), 0);
    q.delete();
    @(posedge clk); #1 rst = 0;
    resp = 1; dly = 2; exp_gap = 4;
    go(1, 1);
    @(negedge clk);
    chk("start_after_rst", int'(busy), 1);
    wait_for("done_after_rst", 100, 0);
    @(negedge clk);
    chk("rst_done_count", n_done - d0, 1);
    chk("rst_no_abort", n_abort - a0, 0);
    chk("rst_jobs_left", q.size(), 0);
    @(posedge clk); #1;
    s0 = n_start; d0 = n_done;
    resp = 1; dly = 4; exp_gap = 6;
    go(1, 2);
    wait_for("ign_first", 50, 2);
    @(posedge clk); #1 cfg_layers = 3; cfg_channels = 3; start = 1;
    @(posedge clk); #1 start = 0;
    wait_for("ign_done", 200, 0);
    @(negedge clk);
    chk("ign_start_count", n_start - s0, 2);
    @(posedge clk); #1 eng_done_man = 1;
    @(posedge clk); #1 eng_done_man = 0;
    cycles(3);
    @(negedge clk);
    chk("ign_idle", int'(busy), 0);
    chk("ign_start_count2", n_start - s0, 2);
    chk("ign_done_count", n_done - d0, 1);
    chk("ign_jobs_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
